router_fsm: RTL and testbench



---
 rtl/router_fsm_pkg.sv | 14 +
 rtl/router_fsm_if.sv | 22 ++
 rtl/router_fsm.sv | 51 +++++
 tb/tb_router_fsm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_fsm_pkg.sv
// router_fsm_pkg: shared router state encoding and topology constants
package router_fsm_pkg;
    localparam int NUM_PORTS = 4;
    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        FFS = 3'd3,
        LAF = 3'd4,
        LP  = 3'd5,
        CPE = 3'd6,
        WTE = 3'd7
    } router_state_e;
endpackage

// File: rtl/router_fsm_if.sv
// router_fsm_if: control-path signals between the router FSM and its neighbours
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       empty_0, empty_1, empty_2, empty_3;
    logic       soft_reset_0, soft_reset_1, soft_reset_2, soft_reset_3;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    modport master (
        output pkt_valid, data_in, fifo_full, empty_0, empty_1, empty_2, empty_3,
               soft_reset_0, soft_reset_1, soft_reset_2, soft_reset_3, parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy
    );
    modport slave (
        input  pkt_valid, data_in, fifo_full, empty_0, empty_1, empty_2, empty_3,
               soft_reset_0, soft_reset_1, soft_reset_2, soft_reset_3, parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// router_fsm: Moore controller sequencing header, payload, stall and parity of each packet
module router_fsm
    import router_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    router_fsm_if.slave bus
);
    router_state_e        state_q, state_d;
    logic [1:0]           addr_q, addr_d;
    logic [NUM_PORTS-1:0] empty, srst;
    logic                 empty_sel, srst_sel;
    assign empty     = {bus.empty_3, bus.empty_2, bus.empty_1, bus.empty_0};
    assign srst      = {bus.soft_reset_3, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign empty_sel = empty[addr_q];
    assign srst_sel  = srst[addr_q];
    assign addr_d    = (state_q == DA) ? bus.data_in : addr_q;
    // Leaving DA looks at the live header, since addr_q only lands on the same edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            DA:      state_d = !bus.pkt_valid ? DA : empty[bus.data_in] ? LFD : WTE;
            LFD:     state_d = LD;
            LD:      state_d = bus.fifo_full ? FFS : !bus.pkt_valid ? LP : LD;
            FFS:     state_d = bus.fifo_full ? FFS : LAF;
            LAF:     state_d = bus.parity_done ? DA : bus.low_pkt_valid ? LP : LD;
            LP:      state_d = CPE;
            CPE:     state_d = bus.fifo_full ? FFS : DA;
            WTE:     state_d = empty_sel ? LFD : WTE;
            default: state_d = DA;
        endcase
        if (state_q != DA && srst_sel) state_d = DA;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DA;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end
    assign bus.detect_add    = state_q == DA;
    assign bus.lfd_state     = state_q == LFD;
    assign bus.ld_state      = state_q == LD;
    assign bus.laf_state     = state_q == LAF;
    assign bus.full_state    = state_q == FFS;
    assign bus.write_enb_reg = state_q == LD || state_q == LP || state_q == LAF;
    assign bus.rst_int_reg   = state_q == CPE;
    assign bus.busy          = !(state_q == DA || state_q == LD);
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed scenario checks of router_fsm outputs per cycle
module tb_router_fsm;
    // Output vector order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy
    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0100;
    localparam logic [7:0] O_LAF = 8'b0001_0101;
    localparam logic [7:0] O_FFS = 8'b0000_1001;
    localparam logic [7:0] O_LP  = 8'b0000_0101;
    localparam logic [7:0] O_CPE = 8'b0000_0011;
    localparam logic [7:0] O_WTE = 8'b0000_0001;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails = 0;
    router_fsm_if bus();
    router_fsm dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    wire [7:0] ov = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                     bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic go_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask
    task automatic header(input logic [1:0] a);
        bus.data_in   = a;
        bus.pkt_valid = 1'b1;
        step();
        step();
    endtask
    task automatic test_reset();
        go_idle();
        checks++;
        if (ov !== O_DA || dut.addr_q !== 2'd0) begin
            fails++;
            $display("FAIL reset_init: got out=%b addr=%0d want out=%b addr=0", ov, dut.addr_q, O_DA);
        end
        bus.empty_2 = 1'b1;
        header(2'd2);
        checks++;
        if (ov !== O_LD || dut.addr_q !== 2'd2) begin
            fails++;
            $display("FAIL reset_pre_ld: got out=%b addr=%0d want out=%b addr=2", ov, dut.addr_q, O_LD);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (ov !== O_DA || dut.addr_q !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid_ld: got out=%b addr=%0d want out=%b addr=0", ov, dut.addr_q, O_DA);
        end
    endtask
    task automatic test_idle();
        bus.pkt_valid = 1'b0;
        bus.data_in   = 2'd3;
        step();
        checks++;
        if (ov !== O_DA || dut.addr_q !== 2'd3) begin
            fails++;
            $display("FAIL idle_da: got out=%b addr=%0d want out=%b addr=3", ov, dut.addr_q, O_DA);
        end
    endtask
    task automatic test_normal();
        logic [7:0] exp [7] = '{O_LFD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DA};
        logic       pv  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.data_in = 2'b10;
        bus.empty_2 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.pkt_valid = pv[i];
            step();
            if (i == 0) bus.data_in = 2'b01;
            checks++;
            if (ov !== exp[i]) begin
                fails++;
                $display("FAIL normal step %0d: got %b want %b", i, ov, exp[i]);
            end
        end
    endtask
    task automatic test_busy_port();
        bus.data_in   = 2'd1;
        bus.empty_1   = 1'b0;
        bus.pkt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.data_in = 2'd0;
            checks++;
            if (ov !== O_WTE) begin
                fails++;
                $display("FAIL busy_wte cycle %0d: got %b want %b", i, ov, O_WTE);
            end
        end
        bus.empty_1 = 1'b1;
        step();
        checks++;
        if (ov !== O_LFD) begin
            fails++;
            $display("FAIL busy_release: got %b want %b", ov, O_LFD);
        end
        go_idle();
    endtask
    task automatic test_full_stall();
        bus.empty_0 = 1'b1;
        header(2'd0);
        bus.fifo_full = 1'b1;
        bus.pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.pkt_valid = 1'b1;
            checks++;
            if (ov !== O_FFS) begin
                fails++;
                $display("FAIL stall_ffs cycle %0d: got %b want %b", i, ov, O_FFS);
            end
        end
        bus.fifo_full     = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        step();
        checks++;
        if (ov !== O_LAF) begin
            fails++;
            $display("FAIL stall_laf: got %b want %b", ov, O_LAF);
        end
        step();
        checks++;
        if (ov !== O_LD) begin
            fails++;
            $display("FAIL stall_back_ld: got %b want %b", ov, O_LD);
        end
        go_idle();
    endtask
    task automatic test_laf_exits();
        bus.empty_3 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            header(2'd3);
            bus.fifo_full = 1'b1;
            step();
            bus.fifo_full = 1'b0;
            step();
            bus.parity_done   = (k == 0);
            bus.low_pkt_valid = 1'b1;
            step();
            bus.parity_done   = 1'b0;
            bus.low_pkt_valid = 1'b0;
            checks++;
            if (ov !== (k == 0 ? O_DA : O_LP)) begin
                fails++;
                $display("FAIL laf_exit_%0d: got %b want %b", k, ov, k == 0 ? O_DA : O_LP);
            end
            if (k == 1) begin
                bus.fifo_full = 1'b1;
                step();
                checks++;
                if (ov !== O_CPE) begin
                    fails++;
                    $display("FAIL lp_to_cpe: got %b want %b", ov, O_CPE);
                end
                step();
                bus.fifo_full = 1'b0;
                checks++;
                if (ov !== O_FFS) begin
                    fails++;
                    $display("FAIL cpe_full: got %b want %b", ov, O_FFS);
                end
            end
            go_idle();
        end
    endtask
    task automatic test_soft_reset();
        bus.empty_3 = 1'b1;
        header(2'd3);
        bus.soft_reset_0 = 1'b1;
        step();
        bus.soft_reset_0 = 1'b0;
        checks++;
        if (ov !== O_LD) begin
            fails++;
            $display("FAIL srst_other_port: got %b want %b", ov, O_LD);
        end
        bus.soft_reset_3 = 1'b1;
        bus.fifo_full    = 1'b1;
        step();
        bus.soft_reset_3 = 1'b0;
        bus.fifo_full    = 1'b0;
        checks++;
        if (ov !== O_DA) begin
            fails++;
            $display("FAIL srst_own_port: got %b want %b", ov, O_DA);
        end
        bus.pkt_valid = 1'b0;
        step();
        checks++;
        if (ov !== O_DA) begin
            fails++;
            $display("FAIL srst_stays_da: got %b want %b", ov, O_DA);
        end
    endtask
    initial begin
        reset             = 1'b1;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.empty_0       = 1'b1;
        bus.empty_1       = 1'b1;
        bus.empty_2       = 1'b1;
        bus.empty_3       = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.soft_reset_3  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        test_reset();
        test_idle();
        test_normal();
        test_busy_port();
        test_full_stall();
        test_laf_exits();
        test_soft_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
